// File: rtl/menu_ctl_pkg.sv
// Shared types and constants for the VGA menu controller.
// State encoding doubles as the text page select code.
package menu_ctl_pkg;

  typedef enum logic [1:0] {
    ST_MAIN = 2'd0,
    ST_INFO = 2'd1,
    ST_GAME = 2'd2,
    ST_OVER = 2'd3
  } menu_state_t;

  localparam logic [3:0] OPT_START = 4'd0;
  localparam logic [3:0] OPT_INFO  = 4'd1;
  localparam logic [3:0] OPT_SCORE = 4'd2;
  localparam logic [3:0] HL_NONE   = 4'hF;
  localparam logic [23:0] CNT_MAX  = 24'hFF_FFFF;

endpackage

// File: rtl/menu_ctl_btn_repeat.sv
// Press-edge detection plus hold-to-repeat for one navigation button.
// evt is combinational so the FSM acts on the same edge the press is sampled.
module btn_repeat
  import menu_ctl_pkg::*;
#(
  parameter logic [23:0] DELAY = 24'd6_500_000,
  parameter logic [23:0] RATE  = 24'd3_250_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic evt
);

  logic        prev_r;
  logic [23:0] cnt_r;
  logic [23:0] cnt_s;
  logic        rpt_s;

  // Repeat fires when the hold count reaches DELAY; reloading to DELAY-RATE+1
  // makes later repeats land every RATE cycles without any modulo.
  always_comb begin
    rpt_s = btn && prev_r && (cnt_r == DELAY);
    evt   = (btn && !prev_r) || rpt_s;
    if (!btn) begin
      cnt_s = 24'd0;
    end else if (rpt_s) begin
      cnt_s = DELAY - RATE + 24'd1;
    end else if (cnt_r != CNT_MAX) begin
      cnt_s = cnt_r + 24'd1;
    end else begin
      cnt_s = cnt_r;
    end
  end

  // Previous-sample and hold-count registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prev_r <= 1'b0;
      cnt_r  <= 24'd0;
    end else begin
      prev_r <= btn;
      cnt_r  <= cnt_s;
    end
  end

endmodule

// File: rtl/menu_ctl.sv
// Menu controller: page FSM, wrapping cursor and one-cycle command pulses
// for the VGA front end; every output comes straight from a register.
module menu_ctl
  import menu_ctl_pkg::*;
#(
  parameter int          N_OPT        = 3,
  parameter logic [3:0]  OPT_ROW0     = 4'd2,
  parameter logic [23:0] REPEAT_DELAY = 24'd6_500_000,
  parameter logic [23:0] REPEAT_RATE  = 24'd3_250_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_sel,
  input  logic       btn_back,
  input  logic       game_over,
  output logic [1:0] page,
  output logic [3:0] cursor,
  output logic [3:0] hl_row,
  output logic       menu_en,
  output logic       game_start,
  output logic       score_clr
);

  localparam logic [3:0] LAST_OPT = 4'(N_OPT - 1);

  menu_state_t state_r, state_s;
  logic [3:0]  cursor_r, cursor_s;
  logic [3:0]  hl_row_r, hl_row_s;
  logic        menu_en_r, start_r, start_s, clr_r, clr_s;
  logic        sel_prev_r, back_prev_r;
  logic        up_evt_s, dn_evt_s, sel_evt_s, back_evt_s;

  btn_repeat #(.DELAY(REPEAT_DELAY), .RATE(REPEAT_RATE)) u_rpt_up (
    .clk(clk), .rst_n(rst_n), .btn(btn_up), .evt(up_evt_s)
  );

  btn_repeat #(.DELAY(REPEAT_DELAY), .RATE(REPEAT_RATE)) u_rpt_dn (
    .clk(clk), .rst_n(rst_n), .btn(btn_down), .evt(dn_evt_s)
  );

  assign sel_evt_s  = btn_sel && !sel_prev_r;
  assign back_evt_s = btn_back && !back_prev_r;

  // Next state, cursor and pulses; sel outranks navigation, up+down cancel.
  always_comb begin
    state_s  = state_r;
    cursor_s = cursor_r;
    start_s  = 1'b0;
    clr_s    = 1'b0;
    case (state_r)
      ST_MAIN: begin
        if (sel_evt_s) begin
          case (cursor_r)
            OPT_START: begin
              state_s = ST_GAME;
              start_s = 1'b1;
            end
            OPT_INFO:  state_s = ST_INFO;
            OPT_SCORE: clr_s = 1'b1;
            default:   state_s = ST_MAIN;
          endcase
        end else if (up_evt_s && !dn_evt_s) begin
          if (cursor_r == 4'd0) cursor_s = LAST_OPT;
          else                  cursor_s = cursor_r - 4'd1;
        end else if (dn_evt_s && !up_evt_s) begin
          if (cursor_r >= LAST_OPT) cursor_s = 4'd0;
          else                      cursor_s = cursor_r + 4'd1;
        end else begin
          cursor_s = cursor_r;
        end
      end
      ST_INFO: begin
        if (sel_evt_s || back_evt_s) state_s = ST_MAIN;
        else                         state_s = ST_INFO;
      end
      ST_GAME: begin
        if (game_over) state_s = ST_OVER;
        else           state_s = ST_GAME;
      end
      ST_OVER: begin
        if (sel_evt_s) begin
          state_s  = ST_MAIN;
          cursor_s = 4'd0;
        end else begin
          state_s = ST_OVER;
        end
      end
      default: state_s = ST_MAIN;
    endcase
    if (state_s == ST_MAIN) hl_row_s = OPT_ROW0 + cursor_s;
    else                    hl_row_s = HL_NONE;
  end

  // State, cursor, output and edge-detect registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r     <= ST_MAIN;
      cursor_r    <= 4'd0;
      hl_row_r    <= OPT_ROW0;
      menu_en_r   <= 1'b1;
      start_r     <= 1'b0;
      clr_r       <= 1'b0;
      sel_prev_r  <= 1'b0;
      back_prev_r <= 1'b0;
    end else begin
      state_r     <= state_s;
      cursor_r    <= cursor_s;
      hl_row_r    <= hl_row_s;
      menu_en_r   <= (state_s != ST_GAME);
      start_r     <= start_s;
      clr_r       <= clr_s;
      sel_prev_r  <= btn_sel;
      back_prev_r <= btn_back;
    end
  end

  assign page       = state_r;
  assign cursor     = cursor_r;
  assign hl_row     = hl_row_r;
  assign menu_en    = menu_en_r;
  assign game_start = start_r;
  assign score_clr  = clr_r;

endmodule

// File: tb/tb_menu_ctl.sv
// Directed self-checking bench for menu_ctl with short repeat timing.
module tb_menu_ctl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       btn_up = 1'b0, btn_down = 1'b0, btn_sel = 1'b0, btn_back = 1'b0;
  logic       game_over = 1'b0;
  logic [1:0] page;
  logic [3:0] cursor, hl_row;
  logic       menu_en, game_start, score_clr;

  int n_checks = 0;
  int n_pass   = 0;

  menu_ctl #(
    .N_OPT(3), .OPT_ROW0(4'd2), .REPEAT_DELAY(24'd10), .REPEAT_RATE(24'd4)
  ) dut (
    .clk(clk), .rst_n(rst_n), .btn_up(btn_up), .btn_down(btn_down),
    .btn_sel(btn_sel), .btn_back(btn_back), .game_over(game_over),
    .page(page), .cursor(cursor), .hl_row(hl_row), .menu_en(menu_en),
    .game_start(game_start), .score_clr(score_clr)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    btn_up = 1'b0; btn_down = 1'b0; btn_sel = 1'b0; btn_back = 1'b0;
    game_over = 1'b0;
    rst_n = 1'b0;
    tick(); tick(); tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++; if (page !== 2'd0) $display("FAIL reset_page got %0d exp 0", page); else n_pass++;
    n_checks++; if (cursor !== 4'd0) $display("FAIL reset_cursor got %0d exp 0", cursor); else n_pass++;
    n_checks++; if (hl_row !== 4'd2) $display("FAIL reset_hl_row got %0d exp 2", hl_row); else n_pass++;
    n_checks++; if (menu_en !== 1'b1) $display("FAIL reset_menu_en got %0b exp 1", menu_en); else n_pass++;
    n_checks++;
    if (game_start !== 1'b0 || score_clr !== 1'b0)
      $display("FAIL reset_pulses got %0b%0b exp 00", game_start, score_clr);
    else n_pass++;
  endtask

  task automatic test_nav_wrap();
    logic [3:0] exp_cur [3];
    exp_cur[0] = 4'd1; exp_cur[1] = 4'd2; exp_cur[2] = 4'd0;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      btn_down = 1'b1;
      tick();
      n_checks++;
      if (cursor !== exp_cur[i]) $display("FAIL nav_down%0d got %0d exp %0d", i, cursor, exp_cur[i]);
      else n_pass++;
      btn_down = 1'b0;
      tick();
    end
    btn_up = 1'b1;
    tick();
    n_checks++; if (cursor !== 4'd2) $display("FAIL nav_up_wrap got %0d exp 2", cursor); else n_pass++;
    n_checks++; if (hl_row !== 4'd4) $display("FAIL nav_up_hl got %0d exp 4", hl_row); else n_pass++;
    btn_up = 1'b0;
    tick();
  endtask

  task automatic test_repeat();
    logic [3:0] exp;
    do_reset();
    btn_down = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (i < 10)      exp = 4'd1;
      else if (i < 14) exp = 4'd2;
      else if (i < 18) exp = 4'd0;
      else             exp = 4'd1;
      n_checks++;
      if (cursor !== exp) $display("FAIL repeat_c%0d got %0d exp %0d", i, cursor, exp);
      else n_pass++;
    end
    btn_down = 1'b0;
    tick();
    btn_up = 1'b1; btn_down = 1'b1;
    for (int i = 0; i < 20; i++) tick();
    n_checks++; if (cursor !== 4'd1) $display("FAIL repeat_updown got %0d exp 1", cursor); else n_pass++;
    n_checks++; if (hl_row !== 4'd3) $display("FAIL repeat_updown_hl got %0d exp 3", hl_row); else n_pass++;
    btn_up = 1'b0; btn_down = 1'b0;
    tick();
  endtask

  task automatic test_game_flow();
    do_reset();
    btn_sel = 1'b1;
    tick();
    n_checks++; if (game_start !== 1'b1) $display("FAIL game_start_pulse got %0b exp 1", game_start); else n_pass++;
    n_checks++; if (page !== 2'd2) $display("FAIL game_page got %0d exp 2", page); else n_pass++;
    n_checks++; if (menu_en !== 1'b0) $display("FAIL game_menu_en got %0b exp 0", menu_en); else n_pass++;
    n_checks++; if (hl_row !== 4'hF) $display("FAIL game_hl got %0d exp 15", hl_row); else n_pass++;
    tick();
    n_checks++; if (game_start !== 1'b0) $display("FAIL game_start_width got %0b exp 0", game_start); else n_pass++;
    btn_sel = 1'b0;
    tick();
    btn_down = 1'b1; btn_back = 1'b1; btn_sel = 1'b1;
    tick();
    btn_down = 1'b0; btn_back = 1'b0; btn_sel = 1'b0;
    btn_up = 1'b1;
    tick();
    btn_up = 1'b0;
    tick();
    n_checks++;
    if (page !== 2'd2 || cursor !== 4'd0 || game_start !== 1'b0)
      $display("FAIL game_ignore got page %0d cur %0d gs %0b exp 2 0 0", page, cursor, game_start);
    else n_pass++;
    game_over = 1'b1;
    tick();
    game_over = 1'b0;
    n_checks++; if (page !== 2'd3) $display("FAIL over_page got %0d exp 3", page); else n_pass++;
    n_checks++; if (menu_en !== 1'b1) $display("FAIL over_menu_en got %0b exp 1", menu_en); else n_pass++;
    btn_sel = 1'b1;
    tick();
    btn_sel = 1'b0;
    n_checks++;
    if (page !== 2'd0 || cursor !== 4'd0 || hl_row !== 4'd2)
      $display("FAIL over_return got page %0d cur %0d hl %0d exp 0 0 2", page, cursor, hl_row);
    else n_pass++;
    n_checks++; if (game_start !== 1'b0) $display("FAIL over_no_restart got %0b exp 0", game_start); else n_pass++;
    tick();
  endtask

  task automatic test_info_score();
    int pulses;
    do_reset();
    btn_down = 1'b1; tick(); btn_down = 1'b0; tick();
    btn_sel = 1'b1;
    tick();
    n_checks++; if (page !== 2'd1) $display("FAIL info_page got %0d exp 1", page); else n_pass++;
    n_checks++; if (hl_row !== 4'hF) $display("FAIL info_hl got %0d exp 15", hl_row); else n_pass++;
    tick();
    n_checks++; if (page !== 2'd1) $display("FAIL info_held_sel got %0d exp 1", page); else n_pass++;
    btn_sel = 1'b0;
    tick();
    btn_back = 1'b1;
    tick();
    btn_back = 1'b0;
    n_checks++;
    if (page !== 2'd0 || cursor !== 4'd1 || hl_row !== 4'd3)
      $display("FAIL info_back got page %0d cur %0d hl %0d exp 0 1 3", page, cursor, hl_row);
    else n_pass++;
    btn_back = 1'b1;
    tick();
    btn_back = 1'b0;
    n_checks++; if (page !== 2'd0) $display("FAIL main_back_ignored got %0d exp 0", page); else n_pass++;
    btn_down = 1'b1; tick(); btn_down = 1'b0; tick();
    pulses = 0;
    btn_sel = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (score_clr === 1'b1) pulses++;
      n_checks++;
      if (page !== 2'd0) $display("FAIL score_page%0d got %0d exp 0", i, page); else n_pass++;
    end
    btn_sel = 1'b0;
    tick();
    n_checks++; if (pulses !== 1) $display("FAIL score_pulses got %0d exp 1", pulses); else n_pass++;
    game_over = 1'b1;
    tick();
    game_over = 1'b0;
    n_checks++; if (page !== 2'd0) $display("FAIL main_game_over_ignored got %0d exp 0", page); else n_pass++;
    btn_sel = 1'b1; btn_down = 1'b1;
    tick();
    n_checks++;
    if (score_clr !== 1'b1 || cursor !== 4'd2)
      $display("FAIL sel_beats_down got clr %0b cur %0d exp 1 2", score_clr, cursor);
    else n_pass++;
    btn_sel = 1'b0; btn_down = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid();
    do_reset();
    btn_sel = 1'b1; tick(); btn_sel = 1'b0; tick();
    btn_down = 1'b1;
    for (int i = 0; i < 12; i++) tick();
    rst_n = 1'b0;
    tick();
    n_checks++;
    if (page !== 2'd0 || cursor !== 4'd0 || hl_row !== 4'd2 || menu_en !== 1'b1)
      $display("FAIL midreset got page %0d cur %0d hl %0d en %0b exp 0 0 2 1", page, cursor, hl_row, menu_en);
    else n_pass++;
    btn_down = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 15; i++) tick();
    n_checks++; if (cursor !== 4'd0) $display("FAIL midreset_no_evt got %0d exp 0", cursor); else n_pass++;
    btn_down = 1'b1;
    for (int i = 0; i < 11; i++) begin
      tick();
      if (i == 9) begin
        n_checks++; if (cursor !== 4'd1) $display("FAIL midreset_hold9 got %0d exp 1", cursor); else n_pass++;
      end
    end
    n_checks++; if (cursor !== 4'd2) $display("FAIL midreset_hold10 got %0d exp 2", cursor); else n_pass++;
    btn_down = 1'b0;
    tick();
    do_reset();
    btn_sel = 1'b1; rst_n = 1'b0;
    tick();
    n_checks++;
    if (game_start !== 1'b0 || page !== 2'd0)
      $display("FAIL reset_beats_sel got gs %0b page %0d exp 0 0", game_start, page);
    else n_pass++;
    btn_sel = 1'b0; rst_n = 1'b1;
    tick();
  endtask

  initial begin
    test_reset();
    test_nav_wrap();
    test_repeat();
    test_game_flow();
    test_info_score();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
